// File: rtl/mix_columns_seq_if.sv
// Handshake and data bundle for the sequential MixColumns stage.
// Valid/ready semantics: pi_start is a request that is taken only on a rising
// edge where po_busy is 0; po_done is a one-cycle pulse during which po_state
// holds the complete result. po_dbg_state mirrors the FSM state for checkers.
interface mix_columns_seq_if;
    logic         pi_start;
    logic [127:0] pi_state;
    logic         pi_inverse;
    logic         po_busy;
    logic         po_done;
    logic [127:0] po_state;
    logic [1:0]   po_dbg_state;

    modport master (
        output pi_start, pi_state, pi_inverse,
        input  po_busy, po_done, po_state, po_dbg_state
    );

    modport slave (
        input  pi_start, pi_state, pi_inverse,
        output po_busy, po_done, po_state, po_dbg_state
    );
endinterface

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: computes BYTES_PER_CYCLE result bytes per RUN
// cycle from a captured 128-bit state. Byte i = bits[127-8i -: 8],
// column c = bytes 4c..4c+3, row r = byte 4c+r.
// Optional feature macro: MIX_INV_EN adds InvMixColumns selected by pi_inverse.
module mix_columns_seq #(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic              pi_clk,
    input  logic              pi_rst,
    mix_columns_seq_if.slave  bus
);
    localparam int RUN_LEN = 16 / BYTES_PER_CYCLE;
    localparam int CW      = $clog2(RUN_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [127:0]  r_in;
    logic [127:0]  r_out;
    logic          r_busy;
    logic          r_done;
`ifdef MIX_INV_EN
    logic          r_inv;
`endif
    logic [127:0]  w_next_out;

    // xtime: multiply by 2 in GF(2^8) with the AES polynomial
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Coefficient code: 2'b0x = x1, 2'b10 = x2, 2'b11 = x3
    function automatic logic [7:0] gmul_fwd(input logic [7:0] b, input logic [1:0] code);
        logic [7:0] res;
        case (code)
            2'b10:   res = xt(b);
            2'b11:   res = xt(b) ^ b;
            default: res = b;
        endcase
        return res;
    endfunction

    // One forward output byte: row r uses {2,3,1,1} rotated right by r
    function automatic logic [7:0] mix_fwd(input logic [31:0] col, input logic [1:0] row);
        logic [7:0] acc;
        logic [1:0] pos;
        logic [1:0] code;
        acc = '0;
        for (int k = 0; k < 4; k++) begin
            pos = 2'(k) - row;
            case (pos)
                2'd0:    code = 2'b10;
                2'd1:    code = 2'b11;
                default: code = 2'b00;
            endcase
            acc = acc ^ gmul_fwd(col[31-8*k -: 8], code);
        end
        return acc;
    endfunction

`ifdef MIX_INV_EN
    // Position in {0E,0B,0D,09}; products built from the x2/x4/x8 chain
    function automatic logic [7:0] gmul_inv(input logic [7:0] b, input logic [1:0] pos);
        logic [7:0] x2, x4, x8, res;
        x2 = xt(b);
        x4 = xt(x2);
        x8 = xt(x4);
        case (pos)
            2'd0:    res = x8 ^ x4 ^ x2;
            2'd1:    res = x8 ^ x2 ^ b;
            2'd2:    res = x8 ^ x4 ^ b;
            default: res = x8 ^ b;
        endcase
        return res;
    endfunction

    // One inverse output byte: row r uses {0E,0B,0D,09} rotated right by r
    function automatic logic [7:0] mix_inv(input logic [31:0] col, input logic [1:0] row);
        logic [7:0] acc;
        acc = '0;
        for (int k = 0; k < 4; k++) begin
            acc = acc ^ gmul_inv(col[31-8*k -: 8], 2'(k) - row);
        end
        return acc;
    endfunction
`endif

    // Result register with this cycle's bytes replaced by their new values
    always_comb begin
        logic [3:0]  w_idx;
        logic [31:0] w_col;
        logic [7:0]  w_byte;
        w_next_out = r_out;
        w_idx      = '0;
        w_col      = '0;
        w_byte     = '0;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            w_idx = 4'(int'(r_cnt) * BYTES_PER_CYCLE + j);
            w_col = r_in[127-32*int'(w_idx[3:2]) -: 32];
`ifdef MIX_INV_EN
            w_byte = r_inv ? mix_inv(w_col, w_idx[1:0]) : mix_fwd(w_col, w_idx[1:0]);
`else
            w_byte = mix_fwd(w_col, w_idx[1:0]);
`endif
            w_next_out[127-8*int'(w_idx) -: 8] = w_byte;
        end
    end

    // Control FSM with registered busy/done and the result register
    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_in    <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef MIX_INV_EN
            r_inv   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.pi_start) begin
                        r_state <= S_RUN;
                        r_in    <= bus.pi_state;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
`ifdef MIX_INV_EN
                        r_inv   <= bus.pi_inverse;
`endif
                    end
                end
                S_RUN: begin
                    r_out <= w_next_out;
                    // Counter parks at its last value; it is cleared leaving DONE
                    if (r_cnt == CW'(RUN_LEN - 1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.po_busy      = r_busy;
    assign bus.po_done      = r_done;
    assign bus.po_state     = r_out;
    assign bus.po_dbg_state = r_state;
endmodule
